// File: rtl/if_fetch_unit.sv
// Instruction-fetch requester: owns the PC, drives the instruction ROM and
// buffers returned instructions in a small FIFO toward IF/ID.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    input  logic        id_ready_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    output logic        misalign_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_ent_t;

    fetch_ent_t    mem_q [FIFO_DEPTH];
    fetch_ent_t    mem_d [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   pc_q, pc_d;
    logic          ce_q, ce_d;
    logic          misalign_q, misalign_d;

    logic          pop, push, redirect;
    logic [31:0]   target;

    assign rom_ce_o   = ce_q;
    assign rom_addr_o = pc_q;
    assign misalign_o = misalign_q;
    assign if_valid_o = (count_q != '0);
    assign if_pc_o    = if_valid_o ? mem_q[rd_ptr_q].pc   : 32'h0;
    assign if_inst_o  = if_valid_o ? mem_q[rd_ptr_q].inst : 32'h0;

    // Next-state: handshake, fetch push, redirect/trap handling.
    always_comb begin
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;

        pop      = if_valid_o & id_ready_i;
        // While trapped only a flush can redirect; branches are dropped.
        redirect = flush_i | (branch_flag_i & ~misalign_q);
        target   = flush_i ? new_pc_i : branch_target_i;
        push     = ce_q & ~redirect & ((count_q < DEPTH_C) | pop);

        if (redirect) begin
            // The head pop (if any) completes; everything else is dropped.
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            pc_d       = target;
            misalign_d = |target[1:0];
        end else begin
            if (push) begin
                mem_d[wr_ptr_d] = '{pc: pc_q, inst: rom_inst_i};
                wr_ptr_d        = wr_ptr_q + AW'(1);
                pc_d            = pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end

        // Fetch is enabled whenever no misalignment trap is pending.
        ce_d = ~misalign_d;
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            pc_q       <= RESET_PC;
            ce_q       <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            pc_q       <= pc_d;
            ce_q       <= ce_d;
            misalign_q <= misalign_d;
        end
    end

endmodule
